fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
Sequences the fetch unit's PC source. Arbitrates redirect requests (trap, execute-stage branch, decode-stage jump) and drives the fetch unit's next_PC_select, target_PC and PC write enable. Also generates flush and inst_valid for the IF/ID register, and honours hazard stalls. Sits between fetch and the decode/execute/hazard logic in the RISC-V core.

Parameters:
ADDRESS_BITS, 16, width of PC and all targets
FLUSH_CYCLES, 2, bubble cycles (inst_valid=0) after a redirect cycle; 0 allowed
TRAP_VECTOR, 16'h0100, redirect address on trap

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset
stall  in  1  hazard stall; freezes PC
trap  in  1  trap request, highest priority
br_taken  in  1  execute-stage taken branch
br_target  in  ADDRESS_BITS  branch target
jal_valid  in  1  decode-stage jump
jal_target  in  ADDRESS_BITS  jump target
PC  in  ADDRESS_BITS  current fetch PC
next_PC_select  out  1  1 = fetch loads target_PC; 0 = PC+4
target_PC  out  ADDRESS_BITS  redirect address
fetch_enable  out  1  fetch PC write enable
flush  out  1  kill IF/ID contents
inst_valid  out  1  fetched instruction is valid
epc  out  ADDRESS_BITS  PC captured on trap

Behaviour:
- Reset (reset=0, async): state=BOOT; next_PC_select=0, target_PC=0, flush=0, inst_valid=0, epc=0, fetch_enable=0. Reset mid-operation drops any pending redirect.
- States: BOOT, RUN, REDIRECT, FLUSH.
- BOOT: lasts exactly 1 cycle after reset deasserts. fetch_enable=0. Then RUN.
- RUN: inst_valid=1. fetch_enable = !stall, combinational so the stall takes effect in the same cycle.
- Request priority at a RUN edge: trap > br_taken > jal_valid.
- Accepting a request: target_PC <= selected target; next_PC_select <= 1; flush <= 1; inst_valid <= 0; state <= REDIRECT. On trap, epc <= PC and target = TRAP_VECTOR.
- Requests are accepted in RUN even while stall=1.
- REDIRECT: fetch_enable = !stall. next_PC_select and target_PC are held until the cycle in which fetch_enable=1. The edge ending that cycle loads the target. After that edge: next_PC_select=0, flush=0, counter=FLUSH_CYCLES, state=FLUSH. If FLUSH_CYCLES=0, go to RUN with inst_valid=1.
- FLUSH: inst_valid=0; fetch_enable=!stall. The counter decrements only on non-stalled cycles. At 0, go to RUN with inst_valid=1.
- br_taken and jal_valid are ignored in REDIRECT and FLUSH, because they come from the squashed wrong path.
- trap is accepted in any non-BOOT state. It re-enters REDIRECT, overwrites target_PC, and updates epc.
- Targets are ADDRESS_BITS wide. No arithmetic is done on them here, since PC+4 wraps inside fetch.
- Misaligned targets (bits[1:0] != 0) are handled per the optional feature.
- next_PC_select, target_PC, flush, inst_valid and epc are registered. fetch_enable is combinational from state and stall.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a branch or jump target with bits[1:0] != 0 is accepted as a trap instead. target_PC=TRAP_VECTOR, epc=PC, and an extra output misalign (1 bit) pulses high for 1 cycle, registered together with REDIRECT entry.
- Undefined: target bits[1:0] are forced to 0 and no misalign port exists.

Test Plan:
- Reset release with no requests → BOOT for 1 cycle (fetch_enable=0), then RUN. With PC from fetch 0000, 0004, 0008…, inst_valid=1 from the 2nd cycle.
- br_taken=1, br_target=16'hFF00 at PC=002c → next cycle next_PC_select=1, target_PC=FF00, flush=1. PC=FF00 on the following edge. inst_valid=0 for 1+FLUSH_CYCLES=3 cycles. PC=FF08 two cycles after FF00.
- trap, br_taken and jal_valid all asserted at PC=0040 → target_PC=0100, epc=0040. Branch and jal are discarded.
- br_taken, br_target=0200 with stall=1 held 3 cycles → fetch_enable=0 and next_PC_select=1 held all 3 cycles. PC loads 0200 on the first edge after stall drops.
- jal_valid during FLUSH → ignored. A trap during FLUSH → REDIRECT to 0100.
- With MISALIGN_TRAP_EN defined, br_target=0202 → trap to 0100 with a misalign pulse. Without it, PC loads 0200.

Source files
------------

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - PC source sequencer for the fetch unit
//
// Purpose:
//   Arbitrates redirect requests (trap > execute-stage branch > decode-stage
//   jump), drives the fetch unit's PC mux select, redirect target and PC write
//   enable, and generates flush / inst_valid for the IF/ID register. Hazard
//   stalls freeze the PC but do not block acceptance of a redirect.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   Defined   - a misaligned branch/jump target becomes a trap; adds misalign.
//   Undefined - target bits[1:0] are forced to zero.
//
// Ports:
//   clock, reset            rising-edge clock, async active-low reset
//   stall                   hazard stall, gates fetch_enable
//   trap                    trap request (highest priority)
//   br_taken, br_target     execute-stage taken branch and target
//   jal_valid, jal_target   decode-stage jump and target
//   PC                      current fetch PC
//   next_PC_select          1 = fetch loads target_PC, 0 = PC+4
//   target_PC               redirect address
//   fetch_enable            fetch PC write enable (combinational)
//   flush                   kill IF/ID contents
//   inst_valid              fetched instruction is valid
//   epc                     PC captured on trap
//   misalign                (MISALIGN_TRAP_EN only) 1-cycle misaligned-target pulse

module fetch_controller #(
  parameter int                      ADDRESS_BITS = 16,
  parameter int                      FLUSH_CYCLES = 2,
  parameter logic [ADDRESS_BITS-1:0] TRAP_VECTOR  = 16'h0100
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    trap,
  input  logic                    br_taken,
  input  logic [ADDRESS_BITS-1:0] br_target,
  input  logic                    jal_valid,
  input  logic [ADDRESS_BITS-1:0] jal_target,
  input  logic [ADDRESS_BITS-1:0] PC,
  output logic                    next_PC_select,
  output logic [ADDRESS_BITS-1:0] target_PC,
  output logic                    fetch_enable,
  output logic                    flush,
  output logic                    inst_valid,
`ifdef MISALIGN_TRAP_EN
  output logic                    misalign,
`endif
  output logic [ADDRESS_BITS-1:0] epc
);

  localparam int CW = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] FLUSH_INIT = CW'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    next_pc_select_q, next_pc_select_d;
  logic [ADDRESS_BITS-1:0] target_pc_q, target_pc_d;
  logic                    flush_q, flush_d;
  logic                    inst_valid_q, inst_valid_d;
  logic [ADDRESS_BITS-1:0] epc_q, epc_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    misalign_q, misalign_d;

  logic                    req_accept;
  logic                    req_trap;
  logic                    req_misalign;
  logic [ADDRESS_BITS-1:0] req_target;

  // Request selection. Branch/jump only count in RUN: in REDIRECT and FLUSH
  // they come from the wrong path that is being squashed.
  always_comb begin
    req_accept   = 1'b0;
    req_trap     = 1'b0;
    req_misalign = 1'b0;
    req_target   = TRAP_VECTOR;
    if (state_q != BOOT && trap) begin
      req_accept = 1'b1;
      req_trap   = 1'b1;
    end else if (state_q == RUN && br_taken) begin
      req_accept = 1'b1;
`ifdef MISALIGN_TRAP_EN
      if (br_target[1:0] != 2'b00) begin
        req_trap     = 1'b1;
        req_misalign = 1'b1;
      end else begin
        req_target = br_target;
      end
`else
      req_target = br_target & {{(ADDRESS_BITS-2){1'b1}}, 2'b00};
`endif
    end else if (state_q == RUN && jal_valid) begin
      req_accept = 1'b1;
`ifdef MISALIGN_TRAP_EN
      if (jal_target[1:0] != 2'b00) begin
        req_trap     = 1'b1;
        req_misalign = 1'b1;
      end else begin
        req_target = jal_target;
      end
`else
      req_target = jal_target & {{(ADDRESS_BITS-2){1'b1}}, 2'b00};
`endif
    end
  end

  // BOOT holds the PC; every other state writes it unless stalled.
  always_comb begin
    fetch_enable = 1'b0;
    if (state_q != BOOT) begin
      fetch_enable = !stall;
    end
  end

  always_comb begin
    state_d          = state_q;
    next_pc_select_d = next_pc_select_q;
    target_pc_d      = target_pc_q;
    flush_d          = flush_q;
    inst_valid_d     = inst_valid_q;
    epc_d            = epc_q;
    cnt_d            = cnt_q;
    misalign_d       = 1'b0;

    if (req_accept) begin
      state_d          = REDIRECT;
      next_pc_select_d = 1'b1;
      target_pc_d      = req_target;
      flush_d          = 1'b1;
      inst_valid_d     = 1'b0;
      misalign_d       = req_misalign;
      if (req_trap) begin
        epc_d = PC;
      end
    end else begin
      case (state_q)
        BOOT: begin
          state_d      = RUN;
          inst_valid_d = 1'b1;
        end
        RUN: begin
          inst_valid_d = 1'b1;
        end
        REDIRECT: begin
          // Target stays presented until fetch actually loads it.
          if (fetch_enable) begin
            next_pc_select_d = 1'b0;
            flush_d          = 1'b0;
            cnt_d            = FLUSH_INIT;
            if (FLUSH_CYCLES == 0) begin
              state_d      = RUN;
              inst_valid_d = 1'b1;
            end else begin
              state_d = FLUSH;
            end
          end
        end
        FLUSH: begin
          if (!stall) begin
            if (cnt_q <= CW'(1)) begin
              cnt_d        = '0;
              state_d      = RUN;
              inst_valid_d = 1'b1;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
        end
        default: begin
          state_d = BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= BOOT;
      next_pc_select_q <= 1'b0;
      target_pc_q      <= '0;
      flush_q          <= 1'b0;
      inst_valid_q     <= 1'b0;
      epc_q            <= '0;
      cnt_q            <= '0;
      misalign_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      next_pc_select_q <= next_pc_select_d;
      target_pc_q      <= target_pc_d;
      flush_q          <= flush_d;
      inst_valid_q     <= inst_valid_d;
      epc_q            <= epc_d;
      cnt_q            <= cnt_d;
      misalign_q       <= misalign_d;
    end
  end

  assign next_PC_select = next_pc_select_q;
  assign target_PC      = target_pc_q;
  assign flush          = flush_q;
  assign inst_valid     = inst_valid_q;
  assign epc            = epc_q;

`ifdef MISALIGN_TRAP_EN
  assign misalign = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed self-checking bench for fetch_controller
//
// Purpose: drives directed redirect/stall/trap sequences with a behavioural
// fetch PC (loads target_PC or PC+4 when fetch_enable) and checks outputs
// against hand-computed values.
// Ports: none (top-level bench).

module tb_fetch_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        trap = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = '0;
  logic        jal_valid = 1'b0;
  logic [15:0] jal_target = '0;
  logic [15:0] PC = '0;
  logic        next_PC_select;
  logic [15:0] target_PC;
  logic        fetch_enable;
  logic        flush;
  logic        inst_valid;
  logic [15:0] epc;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fetch_controller dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .trap           (trap),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .jal_valid      (jal_valid),
    .jal_target     (jal_target),
    .PC             (PC),
    .next_PC_select (next_PC_select),
    .target_PC      (target_PC),
    .fetch_enable   (fetch_enable),
    .flush          (flush),
    .inst_valid     (inst_valid),
`ifdef MISALIGN_TRAP_EN
    .misalign       (misalign),
`endif
    .epc            (epc)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of the fetch unit: sample the controls before the edge,
  // apply them to the PC just after it.
  task automatic tick();
    logic        fe;
    logic        sel;
    logic [15:0] tgt;
    #1;
    fe  = fetch_enable;
    sel = next_PC_select;
    tgt = target_PC;
    @(posedge clock);
    #1;
    if (fe === 1'b1) PC = (sel === 1'b1) ? tgt : PC + 16'd4;
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_nps", next_PC_select, 0);
    check("rst_target", target_PC, 0);
    check("rst_flush", flush, 0);
    check("rst_iv", inst_valid, 0);
    check("rst_epc", epc, 0);
    check("rst_fe", fetch_enable, 0);

    // Release reset: one BOOT cycle, then RUN
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("boot_fe", fetch_enable, 0);
    check("boot_iv", inst_valid, 0);
    tick();
    check("run_iv", inst_valid, 1);
    check("run_fe", fetch_enable, 1);
    check("run_pc0", PC, 16'h0000);
    for (int i = 0; i < 11; i++) tick();
    check("run_pc2c", PC, 16'h002c);

    // Branch to FF00
    br_taken = 1'b1;
    br_target = 16'hFF00;
    tick();
    br_taken = 1'b0;
    check("br_nps", next_PC_select, 1);
    check("br_target", target_PC, 16'hFF00);
    check("br_flush", flush, 1);
    check("br_iv0", inst_valid, 0);
    tick();
    check("br_pc", PC, 16'hFF00);
    check("br_nps_clr", next_PC_select, 0);
    check("br_flush_clr", flush, 0);
    check("br_iv1", inst_valid, 0);
    tick();
    check("br_iv2", inst_valid, 0);
    tick();
    check("br_iv_back", inst_valid, 1);
    check("br_pc_ff08", PC, 16'hFF08);

    // Trap, branch and jump together at PC=0040
    PC = 16'h0040;
    trap = 1'b1;
    br_taken = 1'b1;
    br_target = 16'h0200;
    jal_valid = 1'b1;
    jal_target = 16'h0300;
    tick();
    trap = 1'b0;
    br_taken = 1'b0;
    jal_valid = 1'b0;
    check("trap_target", target_PC, 16'h0100);
    check("trap_epc", epc, 16'h0040);
    check("trap_nps", next_PC_select, 1);
    tick();
    check("trap_pc", PC, 16'h0100);
    tick();
    tick();
    check("trap_pc_run", PC, 16'h0108);
    check("trap_iv", inst_valid, 1);

    // Branch accepted under stall, held 3 cycles
    stall = 1'b1;
    br_taken = 1'b1;
    br_target = 16'h0200;
    #1;
    check("stall_fe_run", fetch_enable, 0);
    tick();
    br_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_fe", fetch_enable, 0);
      check("stall_nps", next_PC_select, 1);
      check("stall_pc", PC, 16'h0108);
      if (i < 2) tick();
    end
    stall = 1'b0;
    #1;
    check("unstall_fe", fetch_enable, 1);
    tick();
    check("unstall_pc", PC, 16'h0200);
    check("unstall_nps", next_PC_select, 0);

    // Jump in FLUSH ignored, trap in FLUSH taken
    jal_valid = 1'b1;
    jal_target = 16'h0500;
    tick();
    jal_valid = 1'b0;
    check("fl_jal_nps", next_PC_select, 0);
    check("fl_jal_iv", inst_valid, 0);
    check("fl_jal_pc", PC, 16'h0204);
    trap = 1'b1;
    tick();
    trap = 1'b0;
    check("fl_trap_nps", next_PC_select, 1);
    check("fl_trap_target", target_PC, 16'h0100);
    check("fl_trap_epc", epc, 16'h0204);
    check("fl_trap_flush", flush, 1);
    tick();
    check("fl_trap_pc", PC, 16'h0100);
    tick();
    tick();
    check("fl_trap_iv", inst_valid, 1);

    // Misaligned branch target
    br_taken = 1'b1;
    br_target = 16'h0202;
    tick();
    br_taken = 1'b0;
`ifdef MISALIGN_TRAP_EN
    check("mis_target", target_PC, 16'h0100);
    check("mis_pulse", misalign, 1);
    check("mis_epc", epc, 16'h0108);
    tick();
    check("mis_pulse_clr", misalign, 0);
    check("mis_pc", PC, 16'h0100);
`else
    check("mis_target", target_PC, 16'h0200);
    tick();
    check("mis_pc", PC, 16'h0200);
`endif
    tick();
    tick();
    check("mis_iv", inst_valid, 1);

    // Reset mid-redirect drops the pending request
    br_taken = 1'b1;
    br_target = 16'h0400;
    tick();
    br_taken = 1'b0;
    check("mrst_pre_nps", next_PC_select, 1);
    reset = 1'b0;
    #1;
    check("mrst_nps", next_PC_select, 0);
    check("mrst_target", target_PC, 0);
    check("mrst_flush", flush, 0);
    check("mrst_iv", inst_valid, 0);
    check("mrst_fe", fetch_enable, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
